// File: rtl/uart_cfg_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_cfg_ctrl_if
// Groups the byte-stream and register-file signals around uart_cfg_ctrl.
//
// Signals (direction as seen by the master = the frame controller):
//   rx_done_tick in   1       1-cycle strobe: rx_data valid
//   rx_data      in   8       received byte
//   tx_done_tick in   1       1-cycle strobe: transmitter finished the byte
//   tx_start     out  1       1-cycle strobe: send tx_data
//   tx_data      out  8       reply byte, stable from tx_start to tx_done_tick
//   cfg_we       out  1       1-cycle register write strobe
//   cfg_addr     out  ADDR_W  register address
//   cfg_wdata    out  8       register write data
//   cfg_rdata    in   8       register read data, combinational from cfg_addr
//   busy         out  1       controller is not idle
//   frame_err    out  1       1-cycle error pulse
//
// master modport: the controller.
// slave modport : the surrounding UART / register file.
// ---------------------------------------------------------------------------
interface uart_cfg_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              rx_done_tick;
    logic [7:0]        rx_data;
    logic              tx_done_tick;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              cfg_we;
    logic [ADDR_W-1:0] cfg_addr;
    logic [7:0]        cfg_wdata;
    logic [7:0]        cfg_rdata;
    logic              busy;
    logic              frame_err;

    modport master (
        input  rx_done_tick, rx_data, tx_done_tick, cfg_rdata,
        output tx_start, tx_data, cfg_we, cfg_addr, cfg_wdata, busy, frame_err
    );

    modport slave (
        output rx_done_tick, rx_data, tx_done_tick, cfg_rdata,
        input  tx_start, tx_data, cfg_we, cfg_addr, cfg_wdata, busy, frame_err
    );
endinterface

// File: rtl/uart_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cfg_ctrl
// Frame parser / sequencer between a UART receiver and a configuration
// register file. Collects 4-byte frames (HDR, CMD, DATA, CHK), performs one
// register write or read per frame, then hands a 1-byte reply to the UART
// transmitter.
//
// Frame: CMD[7] = 1 write / 0 read, CMD[6:ADDR_W] must be zero,
//        CMD[ADDR_W-1:0] = address, CHK = CMD ^ DATA.
// Replies: ACK_BYTE on good write, read data on good read, NAK_BYTE on a
//          checksum or reserved-bit error.
//
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous, active-high reset
//   bus    uart_cfg_ctrl_if.master (rx/tx byte handshake, cfg_* register
//          bus, busy, frame_err)
//
// Build option:
//   CFG_TIMEOUT_EN  when defined, an inter-byte timeout of TIMEOUT_CYC clk
//                   cycles abandons a partial frame (frame_err, no reply).
//                   When undefined a partial frame waits indefinitely.
// ---------------------------------------------------------------------------
module uart_cfg_ctrl #(
    parameter int unsigned ADDR_W      = 4,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           reset,
    uart_cfg_ctrl_if.master bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_CHK  = 3'd3;
    localparam logic [2:0] S_EXEC = 3'd4;
    localparam logic [2:0] S_SEND = 3'd5;
    localparam logic [2:0] S_WAIT = 3'd6;

    // CMD bits between bit 7 and the address field; empty when ADDR_W = 7.
    localparam logic [7:0] RSV_MASK = 8'h7F & ~((8'h01 << ADDR_W) - 8'h01);

    logic [2:0]        state;
    logic [7:0]        cmd_q;
    logic [7:0]        data_q;
    logic [7:0]        chk_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wdata_q;
    logic [7:0]        tx_data_q;
    logic              err_q;

    logic              cmd_ok;
    logic              chk_ok;
    logic              frame_good;
    logic              in_exec;
    logic              timeout_hit;

    assign cmd_ok     = (cmd_q & RSV_MASK) == 8'h00;
    assign chk_ok     = chk_q == (cmd_q ^ data_q);
    assign frame_good = cmd_ok && chk_ok;
    assign in_exec    = (state == S_EXEC);

    // Outputs. cfg_we / the checksum-class error are decoded from the
    // latched frame while in EXEC; everything else comes straight from
    // registers.
    assign bus.cfg_we    = in_exec && frame_good && cmd_q[7];
    assign bus.cfg_addr  = addr_q;
    assign bus.cfg_wdata = wdata_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_start  = (state == S_SEND);
    assign bus.busy      = (state != S_IDLE);
    assign bus.frame_err = err_q || (in_exec && !frame_good);

`ifdef CFG_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            in_frame;

    assign in_frame = (state == S_CMD) || (state == S_DATA) || (state == S_CHK);

    // The counter is 0 in the first cycle after an accepted byte, so the
    // abort pulse lands TIMEOUT_CYC cycles after that byte's strobe. A byte
    // arriving in the deciding cycle wins over the timeout.
    assign timeout_hit = in_frame && !bus.rx_done_tick &&
                         (to_cnt == TO_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (!in_frame || bus.rx_done_tick || timeout_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYC;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= 8'h00;
            data_q    <= 8'h00;
            chk_q     <= 8'h00;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            tx_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                // Non-header bytes are line noise, not errors.
                S_IDLE: begin
                    if (bus.rx_done_tick && (bus.rx_data == HDR_BYTE)) begin
                        state <= S_CMD;
                    end
                end
                S_CMD: begin
                    if (bus.rx_done_tick) begin
                        cmd_q <= bus.rx_data;
                        state <= S_DATA;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (bus.rx_done_tick) begin
                        data_q <= bus.rx_data;
                        state  <= S_CHK;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                // Address and write data move to the output registers only
                // here, so cfg_addr stays put until the next frame executes.
                S_CHK: begin
                    if (bus.rx_done_tick) begin
                        chk_q   <= bus.rx_data;
                        addr_q  <= cmd_q[ADDR_W-1:0];
                        wdata_q <= data_q;
                        state   <= S_EXEC;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                // cfg_rdata is combinational from addr_q, valid this cycle.
                S_EXEC: begin
                    if (!frame_good) begin
                        tx_data_q <= NAK_BYTE;
                    end else if (cmd_q[7]) begin
                        tx_data_q <= ACK_BYTE;
                    end else begin
                        tx_data_q <= bus.cfg_rdata;
                    end
                    err_q <= bus.rx_done_tick;
                    state <= S_SEND;
                end
                S_SEND: begin
                    err_q <= bus.rx_done_tick;
                    state <= S_WAIT;
                end
                // A byte landing together with tx_done is still dropped; the
                // header it may carry is not taken.
                S_WAIT: begin
                    err_q <= bus.rx_done_tick;
                    if (bus.tx_done_tick) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
`timescale 1ns/1ps
module tb_uart_cfg_ctrl;

    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    logic reset;

    int n_tests = 0;
    int n_fail  = 0;
    int we_cnt  = 0;
    int ts_cnt  = 0;
    int fe_cnt  = 0;

    uart_cfg_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    uart_cfg_ctrl #(
        .ADDR_W      (ADDR_W),
        .HDR_BYTE    (8'hA5),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15),
        .TIMEOUT_CYC (50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Register file stand-in: address 2 holds 3C, others read C0|addr.
    assign bus.cfg_rdata = (bus.cfg_addr == 4'd2) ? 8'h3C : {4'hC, bus.cfg_addr};

    always @(negedge clk) begin
        if (bus.cfg_we === 1'b1)    we_cnt++;
        if (bus.tx_start === 1'b1)  ts_cnt++;
        if (bus.frame_err === 1'b1) fe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        step(1);
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bus.tx_done_tick = 1'b1;
        step(1);
        bus.tx_done_tick = 1'b0;
    endtask

    // Full frame with reply handshake; checks EXEC (N+1), SEND (N+2), WAIT.
    task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [7:0] dat,
                            input logic [7:0] chk, input logic exp_we, input logic exp_err,
                            input logic [7:0] exp_reply);
        int we0;
        int ts0;
        send_byte(8'hA5);
        check_eq({tag, "/busy_hdr"}, 32'(bus.busy), 32'd1);
        send_byte(cmd);
        send_byte(dat);
        check_eq({tag, "/no_early_we"}, 32'(bus.cfg_we), 32'd0);
        we0 = we_cnt;
        ts0 = ts_cnt;
        send_byte(chk);
        check_eq({tag, "/we_n1"}, 32'(bus.cfg_we), 32'(exp_we));
        check_eq({tag, "/err_n1"}, 32'(bus.frame_err), 32'(exp_err));
        check_eq({tag, "/no_tx_n1"}, 32'(bus.tx_start), 32'd0);
        if (!exp_err) begin
            check_eq({tag, "/addr"}, 32'(bus.cfg_addr), 32'(cmd[3:0]));
        end
        if (exp_we) begin
            check_eq({tag, "/wdata"}, 32'(bus.cfg_wdata), 32'(dat));
        end
        step(1);
        check_eq({tag, "/tx_start_n2"}, 32'(bus.tx_start), 32'd1);
        check_eq({tag, "/reply"}, 32'(bus.tx_data), 32'(exp_reply));
        check_eq({tag, "/we_off_n2"}, 32'(bus.cfg_we), 32'd0);
        check_eq({tag, "/err_off_n2"}, 32'(bus.frame_err), 32'd0);
        step(1);
        check_eq({tag, "/tx_start_off"}, 32'(bus.tx_start), 32'd0);
        step(3);
        check_eq({tag, "/busy_wait"}, 32'(bus.busy), 32'd1);
        check_eq({tag, "/reply_held"}, 32'(bus.tx_data), 32'(exp_reply));
        pulse_tx_done();
        check_eq({tag, "/idle"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "/we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        check_eq({tag, "/tx_count"}, 32'(ts_cnt - ts0), 32'd1);
    endtask

    initial begin
        int fe0;
        int we0;
        int ts0;

        reset            = 1'b1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.tx_done_tick = 1'b0;
        step(3);

        // Reset state
        check_eq("rst/busy",      32'(bus.busy),      32'd0);
        check_eq("rst/tx_start",  32'(bus.tx_start),  32'd0);
        check_eq("rst/tx_data",   32'(bus.tx_data),   32'd0);
        check_eq("rst/cfg_we",    32'(bus.cfg_we),    32'd0);
        check_eq("rst/cfg_addr",  32'(bus.cfg_addr),  32'd0);
        check_eq("rst/cfg_wdata", 32'(bus.cfg_wdata), 32'd0);
        check_eq("rst/frame_err", 32'(bus.frame_err), 32'd0);
        reset = 1'b0;
        step(2);

        // Good write, good read, bad checksum, reserved CMD bit set
        do_frame("wr",     8'h83, 8'h5C, 8'hDF, 1'b1, 1'b0, 8'h06);
        do_frame("rd",     8'h02, 8'h00, 8'h02, 1'b0, 1'b0, 8'h3C);
        check_eq("rd/addr_hold", 32'(bus.cfg_addr), 32'd2);
        do_frame("badchk", 8'h81, 8'h11, 8'h00, 1'b0, 1'b1, 8'h15);
        do_frame("badcmd", 8'hC3, 8'h00, 8'hC3, 1'b0, 1'b1, 8'h15);

        // Noise before a frame is silently skipped
        fe0 = fe_cnt;
        send_byte(8'h00);
        send_byte(8'hFF);
        step(1);
        check_eq("noise/busy", 32'(bus.busy), 32'd0);
        check_eq("noise/no_err", 32'(fe_cnt - fe0), 32'd0);
        do_frame("noise_wr", 8'h81, 8'hAA, 8'h2B, 1'b1, 1'b0, 8'h06);

        // Byte during EXEC and during WAIT is dropped and flagged
        send_byte(8'hA5);
        send_byte(8'h83);
        send_byte(8'h5C);
        send_byte(8'hDF);
        check_eq("drop/exec_we", 32'(bus.cfg_we), 32'd1);
        send_byte(8'h77);
        check_eq("drop/exec_err", 32'(bus.frame_err), 32'd1);
        check_eq("drop/send_tx", 32'(bus.tx_start), 32'd1);
        step(1);
        check_eq("drop/err_clear", 32'(bus.frame_err), 32'd0);
        send_byte(8'h55);
        check_eq("drop/wait_err", 32'(bus.frame_err), 32'd1);
        check_eq("drop/wait_busy", 32'(bus.busy), 32'd1);
        check_eq("drop/wait_no_tx", 32'(bus.tx_start), 32'd0);
        step(1);
        check_eq("drop/wait_err_clear", 32'(bus.frame_err), 32'd0);
        // tx_done together with a header byte: go idle, header not taken
        bus.rx_data      = 8'hA5;
        bus.rx_done_tick = 1'b1;
        bus.tx_done_tick = 1'b1;
        step(1);
        bus.rx_done_tick = 1'b0;
        bus.tx_done_tick = 1'b0;
        check_eq("ovl/idle", 32'(bus.busy), 32'd0);
        check_eq("ovl/err", 32'(bus.frame_err), 32'd1);
        we0 = we_cnt;
        send_byte(8'h83);
        send_byte(8'h5C);
        send_byte(8'hDF);
        step(2);
        check_eq("ovl/hdr_not_taken", 32'(bus.busy), 32'd0);
        check_eq("ovl/no_we", 32'(we_cnt - we0), 32'd0);
        do_frame("after_drop", 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, 8'h3C);

        // tx_done outside WAIT is ignored
        send_byte(8'hA5);
        pulse_tx_done();
        check_eq("txd_ign/busy", 32'(bus.busy), 32'd1);
        send_byte(8'h84);
        send_byte(8'h12);
        send_byte(8'h96);
        check_eq("txd_ign/we", 32'(bus.cfg_we), 32'd1);
        check_eq("txd_ign/addr", 32'(bus.cfg_addr), 32'd4);
        step(1);
        check_eq("txd_ign/ack", 32'(bus.tx_data), 32'h06);
        step(1);
        pulse_tx_done();
        check_eq("txd_ign/idle", 32'(bus.busy), 32'd0);

        // Asynchronous reset mid-frame
        we0 = we_cnt;
        ts0 = ts_cnt;
        send_byte(8'hA5);
        send_byte(8'h83);
        #2 reset = 1'b1;
        #1;
        check_eq("arst/busy", 32'(bus.busy), 32'd0);
        check_eq("arst/addr", 32'(bus.cfg_addr), 32'd0);
        check_eq("arst/tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("arst/err", 32'(bus.frame_err), 32'd0);
        step(1);
        reset = 1'b0;
        send_byte(8'h5C);
        send_byte(8'hDF);
        step(3);
        check_eq("arst/stay_idle", 32'(bus.busy), 32'd0);
        check_eq("arst/no_we", 32'(we_cnt - we0), 32'd0);
        check_eq("arst/no_tx", 32'(ts_cnt - ts0), 32'd0);
        do_frame("post_rst", 8'h83, 8'h5C, 8'hDF, 1'b1, 1'b0, 8'h06);

`ifdef CFG_TIMEOUT_EN
        // Stall after DATA: abort 50 cycles after the DATA strobe
        ts0 = ts_cnt;
        we0 = we_cnt;
        send_byte(8'hA5);
        send_byte(8'h83);
        send_byte(8'h5C);
        step(48);
        check_eq("to/no_err_early", 32'(bus.frame_err), 32'd0);
        check_eq("to/busy_early", 32'(bus.busy), 32'd1);
        step(1);
        check_eq("to/err", 32'(bus.frame_err), 32'd1);
        check_eq("to/idle", 32'(bus.busy), 32'd0);
        step(5);
        check_eq("to/no_tx", 32'(ts_cnt - ts0), 32'd0);
        check_eq("to/no_we", 32'(we_cnt - we0), 32'd0);
        do_frame("post_to", 8'h02, 8'h00, 8'h02, 1'b0, 1'b0, 8'h3C);
`else
        // Without the timeout a partial frame waits indefinitely
        fe0 = fe_cnt;
        send_byte(8'hA5);
        send_byte(8'h83);
        step(300);
        check_eq("stall/busy", 32'(bus.busy), 32'd1);
        check_eq("stall/no_err", 32'(fe_cnt - fe0), 32'd0);
        send_byte(8'h5C);
        send_byte(8'hDF);
        check_eq("stall/we", 32'(bus.cfg_we), 32'd1);
        step(2);
        pulse_tx_done();
        check_eq("stall/idle", 32'(bus.busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
